// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/exec/mem/wb sequencing,
// memory timeouts and retire counting. Define MC_CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes.
module mc_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int WW       = 5,
    parameter int CW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    opcode,
    input  logic          br_taken,
    input  logic          imem_ack,
    input  logic          dmem_ack,
    output logic          imem_req,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic          ir_we,
    output logic          pc_we,
    output logic [1:0]    pc_sel,
    output logic          rf_we,
    output logic [1:0]    wb_sel,
    output logic          alu_a_sel,
    output logic          alu_b_sel,
    output logic          bus_err,
    output logic          trap,
    output logic [CW-1:0] instret
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // Last count value before the timeout fires; an ack in that cycle still wins.
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERROR
    } state_t;

    state_t        state, state_nxt;
    logic [4:0]    op_q;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic [CW-1:0] instret_q;
    logic          bus_err_q;
    logic          retire, set_bus_err;

    logic          imem_req_raw, dmem_req_raw, dmem_we_raw, ir_we_raw, pc_we_raw, rf_we_raw;
    logic          alu_a_raw, alu_b_raw;
    logic [1:0]    pc_sel_raw, wb_sel_raw;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic          trap_q;
    logic          set_trap;
`endif

    function automatic logic uses_imm(input logic [4:0] op);
        case (op)
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC: uses_imm = 1'b1;
            default:                                              uses_imm = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            op_q      <= '0;
            wait_cnt  <= '0;
            instret_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == S_DECODE)
                op_q <= opcode;
            if (retire)
                instret_q <= instret_q + CW'(1);
            if (set_bus_err)
                bus_err_q <= 1'b1;
        end
    end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)
            trap_q <= 1'b0;
        else if (set_trap)
            trap_q <= 1'b1;
    end
`endif

    always_comb begin
        state_nxt    = state;
        wait_nxt     = '0;
        retire       = 1'b0;
        set_bus_err  = 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        set_trap     = 1'b0;
`endif
        imem_req_raw = 1'b0;
        dmem_req_raw = 1'b0;
        dmem_we_raw  = 1'b0;
        ir_we_raw    = 1'b0;
        pc_we_raw    = 1'b0;
        rf_we_raw    = 1'b0;
        pc_sel_raw   = 2'd0;
        wb_sel_raw   = 2'd0;
        alu_a_raw    = 1'b0;
        alu_b_raw    = 1'b0;

        // ALU operand selects stay stable from EXEC until the result is consumed.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            alu_a_raw = (op_q == OPC_AUIPC);
            alu_b_raw = uses_imm(op_q);
        end

        case (state)
            S_FETCH: begin
                imem_req_raw = 1'b1;
                if (imem_ack) begin
                    ir_we_raw = 1'b1;
                    state_nxt = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_bus_err = 1'b1;
                    state_nxt   = S_ERROR;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                case (op_q)
                    OPC_LOAD, OPC_STORE: state_nxt = S_MEM;
                    OPC_BRANCH: begin
                        pc_we_raw  = 1'b1;
                        pc_sel_raw = br_taken ? 2'd1 : 2'd0;
                        retire     = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: state_nxt = S_WB;
                    OPC_SYSTEM: begin
                        pc_we_raw = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        set_trap  = 1'b1;
                        state_nxt = S_ERROR;
`else
                        pc_we_raw = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                dmem_req_raw = 1'b1;
                dmem_we_raw  = (op_q == OPC_STORE);
                if (dmem_ack) begin
                    if (op_q == OPC_STORE) begin
                        pc_we_raw = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    set_bus_err = 1'b1;
                    state_nxt   = S_ERROR;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            S_WB: begin
                rf_we_raw = 1'b1;
                pc_we_raw = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
                case (op_q)
                    OPC_LOAD:          wb_sel_raw = 2'd1;
                    OPC_JAL, OPC_JALR: wb_sel_raw = 2'd2;
                    OPC_LUI:           wb_sel_raw = 2'd3;
                    default:           wb_sel_raw = 2'd0;
                endcase
                case (op_q)
                    OPC_JAL:  pc_sel_raw = 2'd1;
                    OPC_JALR: pc_sel_raw = 2'd2;
                    default:  pc_sel_raw = 2'd0;
                endcase
            end
            default: state_nxt = S_ERROR;
        endcase
    end

    // Reset masks every output so no write escapes during the aborting cycle.
    assign imem_req  = imem_req_raw & ~rst;
    assign dmem_req  = dmem_req_raw & ~rst;
    assign dmem_we   = dmem_we_raw & ~rst;
    assign ir_we     = ir_we_raw & ~rst;
    assign pc_we     = pc_we_raw & ~rst;
    assign rf_we     = rf_we_raw & ~rst;
    assign pc_sel    = rst ? 2'd0 : pc_sel_raw;
    assign wb_sel    = rst ? 2'd0 : wb_sel_raw;
    assign alu_a_sel = alu_a_raw & ~rst;
    assign alu_b_sel = alu_b_raw & ~rst;
    assign bus_err   = bus_err_q & ~rst;
    assign instret   = rst ? '0 : instret_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign trap      = trap_q & ~rst;
`else
    assign trap      = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl: per-instruction reference of the expected
// control trace, including memory timeouts, mid-MEM reset and MC_CTRL_ILLEGAL_TRAP_EN.
module tb_mc_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int TB_CW    = 6;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [13:0] WB_MASK  = 14'h3FF3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       opcode = '0;
    logic             br_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic             imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we;
    logic             alu_a_sel, alu_b_sel, bus_err, trap;
    logic [1:0]       pc_sel, wb_sel;
    logic [TB_CW-1:0] instret;

    int               compared = 0;
    int               mismatched = 0;
    logic [TB_CW-1:0] model_ret = '0;
    logic [4:0]       op_table [12] = '{OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP, OP_LUI,
                                        OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM, 5'b11111, 5'b00011};

    mc_ctrl #(.MAX_WAIT(MAX_WAIT), .WW(5), .CW(TB_CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .bus_err(bus_err),
        .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] rop();
        return 5'($urandom);
    endfunction

    function automatic logic is_known(input logic [4:0] op);
        return op inside {OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP, OP_LUI,
                          OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
    endfunction

    function automatic logic needs_wb(input logic [4:0] op);
        return op inside {OP_LOAD, OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction

    function automatic logic [13:0] ctrl_vec();
        return {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                alu_a_sel, alu_b_sel, bus_err, trap};
    endfunction

    function automatic logic [13:0] mk(input logic ireq, input logic dreq, input logic dwe,
                                       input logic irwe, input logic pcwe, input logic [1:0] psel,
                                       input logic rfwe, input logic [1:0] wsel, input logic aa,
                                       input logic ab, input logic be, input logic tr);
        return {ireq, dreq, dwe, irwe, pcwe, psel, rfwe, wsel, aa, ab, be, tr};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the falling edge.
    task automatic applyStimulus(input logic ia, input logic da, input logic bt, input logic [4:0] op);
        @(negedge clk);
        rst      = 1'b0;
        imem_ack = ia;
        dmem_ack = da;
        br_taken = bt;
        opcode   = op;
        #1;
    endtask

    task automatic resetCycle();
        @(negedge clk);
        rst      = 1'b1;
        imem_ack = rbit();
        dmem_ack = rbit();
        br_taken = rbit();
        opcode   = rop();
        #1;
        checkOutput("reset outputs", 32'(ctrl_vec()), 32'd0);
        checkOutput("reset instret", 32'(instret), 32'd0);
        model_ret = '0;
    endtask

    task automatic errorHold(input logic is_bus);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rbit(), rbit(), rbit(), rop());
            checkOutput($sformatf("error hold %0d", i), 32'(ctrl_vec()),
                        32'(mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, is_bus, ~is_bus)));
        end
        resetCycle();
    endtask

    // Plays one instruction: iw/dw are the ack delays, rst_k is a MEM cycle to reset in (-1: none).
    task automatic execInstr(input logic [4:0] op, input int iw, input int dw, input logic bt,
                             input int rst_k);
        logic       ack, aa, ab;
        logic [1:0] wsel, psel;
        aa = (op == OP_AUIPC);
        ab = op inside {OP_OPIMM, OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC};
        for (int k = 0; k < MAX_WAIT; k++) begin
            ack = (k == iw);
            applyStimulus(ack, rbit(), rbit(), rop());
            if (k == 0)
                checkOutput("instret", 32'(instret), 32'(model_ret));
            checkOutput($sformatf("fetch op=%02h k=%0d", op, k), 32'(ctrl_vec()),
                        32'(mk(1, 0, 0, ack, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0)));
            if (ack)
                break;
            if (k == MAX_WAIT - 1) begin
                errorHold(1'b1);
                return;
            end
        end
        applyStimulus(rbit(), rbit(), rbit(), op);
        checkOutput($sformatf("decode op=%02h", op), 32'(ctrl_vec()), 32'd0);
        applyStimulus(rbit(), rbit(), bt, rop());
        if (op == OP_LOAD || op == OP_STORE) begin
            checkOutput($sformatf("exec op=%02h", op), 32'(ctrl_vec()),
                        32'(mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, aa, ab, 0, 0)));
        end else if (op == OP_BRANCH) begin
            checkOutput($sformatf("exec branch bt=%0d", bt), 32'(ctrl_vec()),
                        32'(mk(0, 0, 0, 0, 1, {1'b0, bt}, 0, 2'd0, aa, ab, 0, 0)));
            model_ret++;
            return;
        end else if (needs_wb(op)) begin
            checkOutput($sformatf("exec op=%02h", op), 32'(ctrl_vec()),
                        32'(mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, aa, ab, 0, 0)));
        end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!is_known(op)) begin
                checkOutput($sformatf("exec illegal op=%02h", op), 32'(ctrl_vec()), 32'd0);
                errorHold(1'b0);
                return;
            end
`endif
            checkOutput($sformatf("exec sys/unknown op=%02h", op), 32'(ctrl_vec()),
                        32'(mk(0, 0, 0, 0, 1, 2'd0, 0, 2'd0, aa, ab, 0, 0)));
            model_ret++;
            return;
        end
        if (op == OP_LOAD || op == OP_STORE) begin
            for (int k = 0; k < MAX_WAIT; k++) begin
                if (k == rst_k) begin
                    resetCycle();
                    return;
                end
                ack = (k == dw);
                applyStimulus(rbit(), ack, rbit(), rop());
                checkOutput($sformatf("mem op=%02h k=%0d", op, k), 32'(ctrl_vec()),
                            32'(mk(0, 1, op == OP_STORE, 0, ack && op == OP_STORE, 2'd0, 0, 2'd0,
                                   aa, ab, 0, 0)));
                if (ack) begin
                    if (op == OP_STORE) begin
                        model_ret++;
                        return;
                    end
                    break;
                end
                if (k == MAX_WAIT - 1) begin
                    errorHold(1'b1);
                    return;
                end
            end
        end
        wsel = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 :
               (op == OP_LUI) ? 2'd3 : 2'd0;
        psel = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
        applyStimulus(rbit(), rbit(), rbit(), rop());
        checkOutput($sformatf("wb op=%02h", op), 32'(ctrl_vec() & WB_MASK),
                    32'(mk(0, 0, 0, 0, 1, psel, 1, wsel, 0, 0, 0, 0) & WB_MASK));
        model_ret++;
    endtask

    initial begin
        resetCycle();
        resetCycle();
        execInstr(OP_OPIMM, 0, 0, 1'b0, -1);
        execInstr(OP_LOAD, 0, 2, 1'b0, -1);
        execInstr(OP_BRANCH, 0, 0, 1'b1, -1);
        execInstr(OP_BRANCH, 0, 0, 1'b0, -1);
        execInstr(OP_JALR, 1, 0, 1'b0, -1);
        execInstr(OP_STORE, 0, 1, 1'b0, -1);
        execInstr(OP_OP, 3, 0, 1'b0, -1);
        execInstr(OP_LOAD, 0, 3, 1'b0, -1);
        execInstr(OP_OP, 4, 0, 1'b0, -1);
        execInstr(OP_STORE, 0, 4, 1'b0, -1);
        execInstr(5'b11111, 0, 0, 1'b0, -1);
        execInstr(OP_LUI, 0, 0, 1'b0, -1);
        execInstr(OP_LOAD, 0, 5, 1'b0, 1);
        execInstr(OP_JAL, 0, 0, 1'b0, -1);
        for (int n = 0; n < 300; n++) begin
            execInstr(op_table[$urandom_range(0, 11)],
                      ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3)),
                      ($urandom_range(0, 15) == 0) ? 4 : int'($urandom_range(0, 3)),
                      rbit(),
                      ($urandom_range(0, 31) == 0) ? 0 : -1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("final instret", 32'(instret), 32'(model_ret));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
